filter_tap_sequencer: RTL

- Time-shares one MAC/accumulator and filter round-truncate datapath between the left and right audio channels.
- Latches incoming samples and writes each into a per-channel circular delay line.
- Sequences the coefficient and delay-line addresses with MAC clear/enable for each tap, waits out the datapath pipeline, then pulses a per-channel output-valid.
- Sits between the codec sample interface and the filter datapath (coef RAM, delay RAM, MAC, round/truncate).

---
 rtl/filter_tap_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/filter_tap_sequencer.sv
`timescale 1ns/1ps
// filter_tap_sequencer
// Shares one MAC/accumulator and round/truncate datapath between the left
// and right audio channels. Each incoming sample is held until its channel
// is granted. The held sample is written into that channel's circular delay
// line. The sequencer then walks the taps: coefficient k is paired with the
// sample k positions back in the delay line. It waits out the datapath
// pipeline and finally pulses the channel's output-valid.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rf_enable                   sequencer enable (0 = no capture, stay idle)
//   rf_tap_count                taps per sample (0 -> 1, >NUM_TAPS -> NUM_TAPS)
//   samp_valid_l/r, samp_l/r    one-cycle sample strobes and sample data
//   trig_drop_flag_clear        clears the sticky overrun flag
//   data_we, data_wdata         delay-line RAM write strobe and data
//   data_addr                   delay-line RAM address {channel, pointer}
//   coef_addr                   coefficient RAM address (tap index)
//   mac_clr, mac_en             accumulator clear / accumulate strobes
//   ch_sel                      channel in service (0 = left, 1 = right)
//   out_valid_l/r               filter output valid for left / right
//   busy                        sequencer is not idle
//   ro_drop_flag                sticky: a sample arrived while one was pending
module filter_tap_sequencer #(
  parameter int NUM_TAPS = 32,
  parameter int ADDR_W   = 5,
  parameter int PIPE_LAT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rf_enable,
  input  logic [ADDR_W:0]   rf_tap_count,
  input  logic              samp_valid_l,
  input  logic [15:0]       samp_l,
  input  logic              samp_valid_r,
  input  logic [15:0]       samp_r,
  input  logic              trig_drop_flag_clear,
  output logic              data_we,
  output logic [15:0]       data_wdata,
  output logic [ADDR_W:0]   data_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              ch_sel,
  output logic              out_valid_l,
  output logic              out_valid_r,
  output logic              busy,
  output logic              ro_drop_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DRAIN_W = $clog2(PIPE_LAT + 1);
  localparam logic [ADDR_W:0]    TAPS_MAX   = (ADDR_W + 1)'(NUM_TAPS);
  localparam logic [ADDR_W:0]    TAPS_ONE   = (ADDR_W + 1)'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);

  state_t              state_q, state_d;
  logic                ch_q, ch_d;
  logic                last_ch_q, last_ch_d;
  logic                pending_l_q, pending_l_d;
  logic                pending_r_q, pending_r_d;
  logic [15:0]         held_l_q, held_l_d;
  logic [15:0]         held_r_q, held_r_d;
  logic [15:0]         cur_samp_q, cur_samp_d;
  logic [ADDR_W-1:0]   wr_ptr_l_q, wr_ptr_l_d;
  logic [ADDR_W-1:0]   wr_ptr_r_q, wr_ptr_r_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [ADDR_W:0]     taps_q, taps_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                drop_q, drop_d;

  logic                grant;
  logic                grant_ch;
  logic                drop_set;
  logic [ADDR_W-1:0]   cur_ptr;
  logic [ADDR_W-1:0]   mac_ptr;
  logic [ADDR_W:0]     taps_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= 1'b0;
      last_ch_q   <= 1'b1;
      pending_l_q <= 1'b0;
      pending_r_q <= 1'b0;
      held_l_q    <= '0;
      held_r_q    <= '0;
      cur_samp_q  <= '0;
      wr_ptr_l_q  <= '0;
      wr_ptr_r_q  <= '0;
      k_q         <= '0;
      taps_q      <= '0;
      drain_q     <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      last_ch_q   <= last_ch_d;
      pending_l_q <= pending_l_d;
      pending_r_q <= pending_r_d;
      held_l_q    <= held_l_d;
      held_r_q    <= held_r_d;
      cur_samp_q  <= cur_samp_d;
      wr_ptr_l_q  <= wr_ptr_l_d;
      wr_ptr_r_q  <= wr_ptr_r_d;
      k_q         <= k_d;
      taps_q      <= taps_d;
      drain_q     <= drain_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    last_ch_d   = last_ch_q;
    pending_l_d = pending_l_q;
    pending_r_d = pending_r_q;
    held_l_d    = held_l_q;
    held_r_d    = held_r_q;
    cur_samp_d  = cur_samp_q;
    wr_ptr_l_d  = wr_ptr_l_q;
    wr_ptr_r_d  = wr_ptr_r_q;
    k_d         = k_q;
    taps_d      = taps_q;
    drain_d     = drain_q;
    drop_d      = drop_q;
    grant       = 1'b0;
    grant_ch    = 1'b0;
    drop_set    = 1'b0;
    data_we     = 1'b0;
    data_wdata  = '0;
    data_addr   = '0;
    coef_addr   = '0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    out_valid_l = 1'b0;
    out_valid_r = 1'b0;

    cur_ptr = ch_q ? wr_ptr_r_q : wr_ptr_l_q;
    mac_ptr = cur_ptr - k_q;

    if (rf_tap_count == '0) begin
      taps_req = TAPS_ONE;
    end else if (rf_tap_count > TAPS_MAX) begin
      taps_req = TAPS_MAX;
    end else begin
      taps_req = rf_tap_count;
    end

    case (state_q)
      S_IDLE: begin
        // On a tie the channel not served last time wins.
        if (rf_enable && (pending_l_q || pending_r_q)) begin
          grant      = 1'b1;
          grant_ch   = (pending_l_q && pending_r_q) ? ~last_ch_q : pending_r_q;
          ch_d       = grant_ch;
          last_ch_d  = grant_ch;
          // Copy the held sample out, so a new sample can be captured in the grant cycle.
          cur_samp_d = grant_ch ? held_r_q : held_l_q;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        data_we    = 1'b1;
        data_addr  = {ch_q, cur_ptr};
        data_wdata = cur_samp_q;
        mac_clr    = 1'b1;
        taps_d     = taps_req;
        k_d        = '0;
        state_d    = S_MAC;
      end
      S_MAC: begin
        mac_en    = 1'b1;
        coef_addr = k_q;
        data_addr = {ch_q, mac_ptr};
        if ({1'b0, k_q} == (taps_q - TAPS_ONE)) begin
          drain_d = DRAIN_LOAD;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_DONE: begin
        if (ch_q) begin
          out_valid_r = 1'b1;
          wr_ptr_r_d  = wr_ptr_r_q + 1'b1;
        end else begin
          out_valid_l = 1'b1;
          wr_ptr_l_d  = wr_ptr_l_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A grant frees the holding register in the same cycle, so a sample
    // arriving then is accepted rather than dropped.
    if (!rf_enable) begin
      pending_l_d = 1'b0;
      pending_r_d = 1'b0;
    end else begin
      if (grant && !grant_ch) pending_l_d = 1'b0;
      if (grant && grant_ch)  pending_r_d = 1'b0;
      if (samp_valid_l) begin
        if (pending_l_d) begin
          drop_set = 1'b1;
        end else begin
          held_l_d    = samp_l;
          pending_l_d = 1'b1;
        end
      end
      if (samp_valid_r) begin
        if (pending_r_d) begin
          drop_set = 1'b1;
        end else begin
          held_r_d    = samp_r;
          pending_r_d = 1'b1;
        end
      end
    end

    // A set in the same cycle as a clear wins.
    if (trig_drop_flag_clear) drop_d = 1'b0;
    if (drop_set)             drop_d = 1'b1;
  end

  assign busy         = (state_q != S_IDLE);
  assign ch_sel       = busy ? ch_q : 1'b0;
  assign ro_drop_flag = drop_q;

endmodule
